display_timing_gen: RTL
=======================

DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

Interface
REQ-001 SHALL have parameters: H_ACTIVE 1280 (visible pixels/line); H_FP 110; H_SYNC 40; H_BP 220; V_ACTIVE 720 (visible lines); V_FP 5; V_SYNC 5; V_BP 20; SYNC_POL 1 (VGA sync active level); BG_COLOR 24'h000000 (RGB when no layer hit).
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 i_clk  in  1  pixel clock (74.25 MHz at default parameters).
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 o_x  out  16  current horizontal coordinate, drives compositor i_x.
REQ-006 o_y  out  16  current vertical coordinate, drives compositor i_y.
REQ-007 o_v_sync  out  1  always active-high frame sync, drives compositor i_v_sync; its rising edge advances sprite motion.
REQ-008 i_red / i_green / i_blue  in  8 each  layer colour returned for (o_x, o_y) in the same cycle.
REQ-009 i_sprite_hit  in  1  layer pixel is opaque.
REQ-010 o_vga_r / o_vga_g / o_vga_b  out  8 each  registered panel colour.
REQ-011 o_vga_hs, o_vga_vs  out  1  panel syncs at level SYNC_POL; o_vga_de  out  1  data enable.
REQ-012 o_frame_start  out  1  one-cycle pulse at (0,0); o_frame_count  out  16  completed frames.

Function
REQ-013 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750); segment order active, front porch, sync, back porch.
REQ-014 o_x SHALL increment by 1 every cycle and wrap H_TOTAL-1 -> 0; o_y SHALL increment only on that wrap and wrap V_TOTAL-1 -> 0.
REQ-015 o_x/o_y SHALL be registered counter values, valid in blanking; they never exceed H_TOTAL-1 / V_TOTAL-1.
REQ-016 Stage-0 hs = (o_x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]) = [1390,1429].
REQ-017 o_v_sync SHALL be high for all cycles with o_y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [725,729], changing only when o_x = 0; registered, glitch-free.
REQ-018 Stage-0 de = (o_x < H_ACTIVE) && (o_y < V_ACTIVE).
REQ-019 Pixel pipeline latency SHALL be exactly 1 cycle: i_* sampled with stage-0 coordinates appear on o_vga_* at the next edge, with o_vga_hs/vs/de delayed 1 cycle to stay aligned.
REQ-020 Colour select: stage-0 de=0 -> 0; de=1 and i_sprite_hit=1 -> {i_red,i_green,i_blue}; de=1 and i_sprite_hit=0 -> BG_COLOR; X on i_* while i_sprite_hit=0 or de=0 SHALL NOT propagate.
REQ-021 o_vga_hs = SYNC_POL when delayed hs=1, else ~SYNC_POL; o_vga_vs likewise from delayed o_v_sync.
REQ-022 o_frame_start SHALL be 1 exactly in cycles where o_x=0 and o_y=0, not delayed.
REQ-023 o_frame_count SHALL increment by 1 on the o_x/o_y wrap (H_TOTAL-1,V_TOTAL-1) -> (0,0), wrapping 16'hFFFF -> 0.

Reset
REQ-024 While i_rst=1 at an edge: o_x=0, o_y=0, o_v_sync=0, o_vga_r/g/b=0, o_vga_de=0, o_vga_hs=o_vga_vs=~SYNC_POL, o_frame_count=0; reset dominates any concurrent counter wrap.
REQ-025 First edge after release SHALL advance o_x to 1; o_frame_start=1 in the first post-reset cycle (0,0); the pipeline register SHALL show stage-0 values from then on; reset mid-frame SHALL abandon the frame without incrementing o_frame_count.

Verification
REQ-026 Release reset -> o_x 0..1649 then 0 with o_y 0->1; after 1,237,500 cycles o_x=o_y=0, o_frame_count=1, o_frame_start pulses once.
REQ-027 Line sweep -> o_vga_hs = SYNC_POL for exactly 40 cycles, first at the edge after o_x=1390; o_vga_de high 1280 cycles per active line, 0 on lines 720-749.
REQ-028 Frame sweep -> o_v_sync rises once per frame at (0,725), high exactly 8250 cycles; o_vga_vs follows 1 cycle later.
REQ-029 At (10,10) drive i_sprite_hit=1, RGB 05/C5/FF -> next cycle o_vga = 05C5FF, de=1; i_sprite_hit=0, RGB=X -> BG_COLOR; at (1300,10) hit=1 -> 000000, de=0.
REQ-030 Assert i_rst at (800,400) for 3 cycles -> outputs at reset values, first post-release cycle at (0,0), o_frame_count=0, no o_v_sync pulse.
REQ-031 Small parameters (all porch/sync 1, actives 2, total 5x5) run for 65,536 frames -> o_frame_count wraps FFFF -> 0000 on the same edge as the (0,0) wrap.

Source files
------------

// File: rtl/display_timing_gen.sv
// Raster timing generator with a one-stage pixel output register.
// Walks (x,y) over the full frame, derives syncs/DE, and registers the composited colour.
module display_timing_gen #(
  parameter int          H_ACTIVE = 1280,
  parameter int          H_FP     = 110,
  parameter int          H_SYNC   = 40,
  parameter int          H_BP     = 220,
  parameter int          V_ACTIVE = 720,
  parameter int          V_FP     = 5,
  parameter int          V_SYNC   = 5,
  parameter int          V_BP     = 20,
  parameter bit          SYNC_POL = 1'b1,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_v_sync,
  input  logic [7:0]  i_red,
  input  logic [7:0]  i_green,
  input  logic [7:0]  i_blue,
  input  logic        i_sprite_hit,
  output logic [7:0]  o_vga_r,
  output logic [7:0]  o_vga_g,
  output logic [7:0]  o_vga_b,
  output logic        o_vga_hs,
  output logic        o_vga_vs,
  output logic        o_vga_de,
  output logic        o_frame_start,
  output logic [15:0] o_frame_count
);

  localparam logic [15:0] H_LAST   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_LAST   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] HA       = 16'(H_ACTIVE);
  localparam logic [15:0] VA       = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic        x_wrap, y_wrap, frame_wrap;
  logic [15:0] x_next, y_next;
  logic        vs_next, hs0, de0;
  logic [23:0] pix0;

  always_comb begin
    x_wrap     = (o_x == H_LAST);
    y_wrap     = (o_y == V_LAST);
    frame_wrap = x_wrap && y_wrap;
    x_next     = x_wrap ? 16'd0 : o_x + 16'd1;
    y_next     = o_y;
    if (x_wrap) y_next = y_wrap ? 16'd0 : o_y + 16'd1;
    // Computed from the next row so the registered vsync only moves with the line wrap.
    vs_next    = (y_next >= VS_START) && (y_next <= VS_END);
    hs0        = (o_x >= HS_START) && (o_x <= HS_END);
    de0        = (o_x < HA) && (o_y < VA);
    // Ternary with a known select keeps unknown layer colour out of blanking/background.
    pix0       = 24'h000000;
    if (de0) pix0 = i_sprite_hit ? {i_red, i_green, i_blue} : BG_COLOR;
  end

  assign o_frame_start = (o_x == 16'd0) && (o_y == 16'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_x                         <= 16'd0;
      o_y                         <= 16'd0;
      o_v_sync                    <= 1'b0;
      o_frame_count               <= 16'd0;
      {o_vga_r, o_vga_g, o_vga_b} <= 24'h000000;
      o_vga_de                    <= 1'b0;
      o_vga_hs                    <= ~SYNC_POL;
      o_vga_vs                    <= ~SYNC_POL;
    end else begin
      o_x      <= x_next;
      o_y      <= y_next;
      o_v_sync <= vs_next;
      if (frame_wrap) o_frame_count <= o_frame_count + 16'd1;
      {o_vga_r, o_vga_g, o_vga_b} <= pix0;
      o_vga_de <= de0;
      o_vga_hs <= hs0 ? SYNC_POL : ~SYNC_POL;
      o_vga_vs <= o_v_sync ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule
